time_set_ctrl: RTL and testbench
================================

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, 1000000, clk cycles a synchronized button level must stay stable before it is accepted (20 ms at 50 MHz).
REQ-002 Parameter: TIMEOUT_CYCLES, 500000000, idle clk cycles in a set state before the edit is abandoned (10 s at 50 MHz).
REQ-003 Port: clk  input  1  system clock.
REQ-004 Port: reset  input  1  reset, asynchronous, active-low.
REQ-005 Port: btn_mode  input  1  raw push button, active-low, asynchronous to clk.
REQ-006 Port: btn_inc  input  1  raw push button, active-low, asynchronous to clk.
REQ-007 Port: time_h  input  8  current hours, packed BCD [7:4] tens, [3:0] units.
REQ-008 Port: time_m  input  8  current minutes, packed BCD.
REQ-009 Port: set_h  output  8  edited hours, packed BCD, 00..23.
REQ-010 Port: set_m  output  8  edited minutes, packed BCD, 00..59.
REQ-011 Port: load_h / load_m  output  1 each  one-cycle commit strobes for the hour and minute counters.
REQ-012 Port: set_active  output  1  high while editing; holds the time counters.
REQ-013 Port: sel  output  2  field under edit: 00 none, 01 hours, 10 minutes; 11 never driven.

Function
REQ-014 Each button SHALL pass through a 2-flop synchronizer, then debounce: accepted level updates only after DEBOUNCE_CYCLES consecutive equal samples; any change restarts the count.
REQ-015 A press event SHALL be a single-cycle pulse, generated on the accepted level going released->pressed; exactly one event per physical press, none on release.
REQ-016 FSM states SHALL be RUN, SET_H, SET_M; transitions occur on the clk edge after the event cycle.
REQ-017 RUN + mode event: capture time_h/time_m into set_h/set_m, go SET_H.
REQ-018 SET_H + inc event: set_h BCD-increments, 23 wraps to 00, units 9 carries to tens.
REQ-019 SET_H + mode event: go SET_M.
REQ-020 SET_M + inc event: set_m BCD-increments, 59 wraps to 00.
REQ-021 SET_M + mode event: assert load_h and load_m together for exactly one cycle, go RUN.
REQ-022 Inc events in RUN SHALL be ignored.
REQ-023 Mode and inc events in the same cycle: mode wins, inc discarded.
REQ-024 Timeout counter SHALL clear on entry to SET_H and on every event; reaching TIMEOUT_CYCLES in SET_H/SET_M returns to RUN with no load strobe, and set_h/set_m keep their values.
REQ-025 set_active SHALL be 1 exactly in SET_H/SET_M, deasserting in the cycle the load strobes fire.
REQ-026 sel SHALL be 01 in SET_H, 10 in SET_M, 00 in RUN.
REQ-027 set_h/set_m SHALL change only by capture (REQ-017) or increment; out-of-range captured BCD SHALL increment to 00.

Reset
REQ-028 reset low SHALL immediately force: state RUN, set_h=8'h00, set_m=8'h00, load_h=load_m=0, set_active=0, sel=00, debounce and timeout counters 0, accepted button levels released.
REQ-029 Reset mid-edit SHALL abandon the edit with no load strobe; after release the FSM starts in RUN.

Configuration
REQ-030 Macro TIME_SET_DEBOUNCE_EN defined: debounce per REQ-014.
REQ-031 Macro TIME_SET_DEBOUNCE_EN undefined: debounce stage removed, synchronizer output used directly as the accepted level; DEBOUNCE_CYCLES ignored; all other behaviour unchanged.

Verification (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=100, macro defined unless stated)
REQ-032 time_h=8'h17, time_m=8'h42, press mode -> set_h=17, set_m=42, sel=01, set_active=1; then 7 inc presses -> set_h=8'h00 (wrap after 23).
REQ-033 Mode to SET_M, 18 inc presses from 42 -> set_m=8'h00; mode -> load_h=load_m=1 for one cycle, set_active=0, sel=00.
REQ-034 btn_mode glitch pressed for 3 cycles -> no event, state unchanged; held pressed 20 cycles -> exactly one event.
REQ-035 In SET_H, no press for 100 cycles -> state RUN, no load strobe, set_h retains value.
REQ-036 Mode and inc events in the same cycle in SET_H -> SET_M entered, set_h unchanged; reset low in SET_M -> all outputs at reset values immediately.
REQ-037 Macro undefined: 3-cycle press -> one event 2 cycles (synchronizer) after press start.

Source files
------------

// File: rtl/time_set_ctrl.sv
// Time-set controller: two debounced buttons drive a RUN -> SET_H -> SET_M edit of a BCD clock.
// Debounce stage present only when TIME_SET_DEBOUNCE_EN is defined; otherwise the synchronizer output is used directly.
module time_set_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int TIMEOUT_CYCLES  = 500000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [7:0] time_h,
    input  logic [7:0] time_m,
    output logic [7:0] set_h,
    output logic [7:0] set_m,
    output logic       load_h,
    output logic       load_m,
    output logic       set_active,
    output logic [1:0] sel
);

    // State encoding equals the sel output, so sel doubles as the FSM debug view.
    localparam logic [1:0] ST_RUN   = 2'b00;
    localparam logic [1:0] ST_SET_H = 2'b01;
    localparam logic [1:0] ST_SET_M = 2'b10;

    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    // Bit 0 = mode, bit 1 = inc; 1 means pressed throughout.
    logic [1:0] sync1_q, sync2_q;
    logic [1:0] level;
    logic [1:0] level_prev_q;
    logic [1:0] evt;
    logic       mode_evt, inc_evt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
        end else begin
            sync1_q <= {~btn_inc, ~btn_mode};
            sync2_q <= sync1_q;
        end
    end

`ifdef TIME_SET_DEBOUNCE_EN
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]            level_q;
    logic [1:0][DB_W-1:0]  db_cnt_q;

    // A sample equal to the accepted level restarts the count; DEBOUNCE_CYCLES differing samples in a row flip it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level_q  <= 2'b00;
            db_cnt_q <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == level_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DB_LAST) begin
                    level_q[i]  <= sync2_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign level = level_q;
`else
    assign level = sync2_q;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level_prev_q <= 2'b00;
        end else begin
            level_prev_q <= level;
        end
    end

    assign evt      = level & ~level_prev_q;
    assign mode_evt = evt[0];
    assign inc_evt  = evt[1];

    // Out-of-range values (bad digits or beyond the wrap point) step to 00.
    function automatic logic [7:0] bcd_inc_h(input logic [7:0] v);
        if (v[3:0] > 4'd9 || v[7:4] > 4'd2 || (v[7:4] == 4'd2 && v[3:0] >= 4'd3)) begin
            return 8'h00;
        end else if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end else begin
            return {v[7:4], v[3:0] + 4'd1};
        end
    endfunction

    function automatic logic [7:0] bcd_inc_m(input logic [7:0] v);
        if (v[3:0] > 4'd9 || v[7:4] > 4'd5 || v == 8'h59) begin
            return 8'h00;
        end else if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end else begin
            return {v[7:4], v[3:0] + 4'd1};
        end
    endfunction

    logic [1:0]       state_q, state_d;
    logic [7:0]       set_h_q, set_h_d;
    logic [7:0]       set_m_q, set_m_d;
    logic             load_q, load_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;

    // Mode has priority over inc; any event restarts the idle timeout.
    always_comb begin
        state_d = state_q;
        set_h_d = set_h_q;
        set_m_d = set_m_q;
        load_d  = 1'b0;
        tmo_d   = tmo_q;
        case (state_q)
            ST_RUN: begin
                tmo_d = '0;
                if (mode_evt) begin
                    set_h_d = time_h;
                    set_m_d = time_m;
                    state_d = ST_SET_H;
                end
            end
            ST_SET_H: begin
                if (mode_evt) begin
                    state_d = ST_SET_M;
                    tmo_d   = '0;
                end else if (inc_evt) begin
                    set_h_d = bcd_inc_h(set_h_q);
                    tmo_d   = '0;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ST_RUN;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_SET_M: begin
                if (mode_evt) begin
                    load_d  = 1'b1;
                    state_d = ST_RUN;
                    tmo_d   = '0;
                end else if (inc_evt) begin
                    set_m_d = bcd_inc_m(set_m_q);
                    tmo_d   = '0;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ST_RUN;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_RUN;
                tmo_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
            set_h_q <= 8'h00;
            set_m_q <= 8'h00;
            load_q  <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            set_h_q <= set_h_d;
            set_m_q <= set_m_d;
            load_q  <= load_d;
            tmo_q   <= tmo_d;
        end
    end

    assign set_h      = set_h_q;
    assign set_m      = set_m_q;
    assign load_h     = load_q;
    assign load_m     = load_q;
    assign set_active = (state_q != ST_RUN);
    assign sel        = state_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: per-cycle scoreboard against a behavioural model, edit-session table,
// hand-written corner sequences and random button traffic. Honours TIME_SET_DEBOUNCE_EN like the design.
module tb_time_set_ctrl;

    localparam int DB  = 4;
    localparam int TMO = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       btn_mode = 1'b1;
    logic       btn_inc = 1'b1;
    logic [7:0] time_h = 8'h00;
    logic [7:0] time_m = 8'h00;
    logic [7:0] set_h, set_m;
    logic       load_h, load_m, set_active;
    logic [1:0] sel;

    time_set_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .reset     (rst_n),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .time_h    (time_h),
        .time_m    (time_m),
        .set_h     (set_h),
        .set_m     (set_m),
        .load_h    (load_h),
        .load_m    (load_m),
        .set_active(set_active),
        .sel       (sel)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int load_cnt = 0;
    logic [20:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_field;   // 0 running, 1 editing hours, 2 editing minutes
    int         m_idle;
    logic [7:0] m_h, m_m;
    logic       m_load;
    logic [1:0] lvl_cur, lvl_prev;
    logic [1:0] hist[$];   // hist[0] = raw pressed levels at this edge, hist[i] = i edges ago

    function automatic logic [7:0] next_h(input logic [7:0] b);
        int t, u, v;
        t = int'(b[7:4]);
        u = int'(b[3:0]);
        v = t * 10 + u;
        v = (u > 9 || v >= 23) ? 0 : v + 1;
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    function automatic logic [7:0] next_m(input logic [7:0] b);
        int t, u, v;
        t = int'(b[7:4]);
        u = int'(b[3:0]);
        v = t * 10 + u;
        v = (u > 9 || v >= 59) ? 0 : v + 1;
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    function automatic logic [1:0] sel_of(input int f);
        return (f == 1) ? 2'b01 : (f == 2) ? 2'b10 : 2'b00;
    endfunction

    task automatic model_step();
        logic [1:0] ev, nl;
        logic       same;
        if (!rst_n) begin
            m_field = 0; m_idle = 0; m_h = 8'h00; m_m = 8'h00; m_load = 1'b0;
            lvl_cur = 2'b00; lvl_prev = 2'b00;
            hist.delete();
            for (int i = 0; i < DB + 2; i++) hist.push_back(2'b00);
        end else begin
            ev = lvl_cur & ~lvl_prev;
            m_load = 1'b0;
            if (m_field == 0) begin
                m_idle = 0;
                if (ev[0]) begin m_h = time_h; m_m = time_m; m_field = 1; end
            end else begin
                if (ev[0]) begin
                    if (m_field == 2) begin m_load = 1'b1; m_field = 0; end
                    else m_field = 2;
                    m_idle = 0;
                end else if (ev[1]) begin
                    if (m_field == 1) m_h = next_h(m_h);
                    else m_m = next_m(m_m);
                    m_idle = 0;
                end else begin
                    m_idle++;
                    if (m_idle == TMO) begin m_field = 0; m_idle = 0; end
                end
            end
            hist.push_front({~btn_inc, ~btn_mode});
            void'(hist.pop_back());
`ifdef TIME_SET_DEBOUNCE_EN
            for (int b = 0; b < 2; b++) begin
                same = 1'b1;
                for (int j = 0; j < DB; j++) if (hist[j+2][b] != hist[2][b]) same = 1'b0;
                nl[b] = same ? hist[2][b] : lvl_cur[b];
            end
`else
            same = 1'b0;
            nl = hist[1];
`endif
            lvl_prev = lvl_cur;
            lvl_cur = nl;
        end
    endtask

    // Scoreboard: model expectation queued at the edge, DUT compared 1 time unit later.
    always @(posedge clk) begin : sb
        logic [20:0] e, a;
        model_step();
        exp_q.push_back({m_h, m_m, m_load, m_load, (m_field != 0), sel_of(m_field)});
        #1;
        e = exp_q.pop_front();
        a = {set_h, set_m, load_h, load_m, set_active, sel};
        n_cmp++;
        if (a !== e) begin
            n_err++;
            $display("FAIL scoreboard t=%0t: got h=%h m=%h ld=%b%b act=%b sel=%b expected h=%h m=%h ld=%b%b act=%b sel=%b",
                     $time, a[20:13], a[12:5], a[4], a[3], a[2], a[1:0],
                     e[20:13], e[12:5], e[4], e[3], e[2], e[1:0]);
        end
    end

    always @(posedge clk) begin : load_mon
        #1;
        if (load_h) load_cnt++;
    end

    // ---------------- drivers ----------------
    task automatic press(input bit m, input bit i, input int hold, input int gap);
        @(negedge clk);
        if (m) btn_mode = 1'b0;
        if (i) btn_inc = 1'b0;
        repeat (hold) @(negedge clk);
        btn_mode = 1'b1;
        btn_inc = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] th;
        logic [7:0] tm;
        int         nh;
        int         nm;
        logic [7:0] eh;
        logic [7:0] em;
    } vec_t;

    vec_t tv[8];

    initial begin
        tv[0] = '{8'h17, 8'h42, 7, 18, 8'h00, 8'h00};
        tv[1] = '{8'h23, 8'h59, 1, 1, 8'h00, 8'h00};
        tv[2] = '{8'h09, 8'h09, 1, 1, 8'h10, 8'h10};
        tv[3] = '{8'h19, 8'h50, 5, 9, 8'h00, 8'h59};
        tv[4] = '{8'h2A, 8'h6F, 1, 1, 8'h00, 8'h00};
        tv[5] = '{8'h12, 8'h34, 3, 30, 8'h15, 8'h04};
        tv[6] = '{8'h00, 8'h00, 0, 0, 8'h00, 8'h00};
        tv[7] = '{8'h22, 8'h05, 25, 2, 8'h23, 8'h07};

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check("reset_outputs", {11'd0, set_h, set_m, load_h, load_m, set_active, sel}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Table of full edit sessions
        for (int k = 0; k < 8; k++) begin
            time_h = tv[k].th;
            time_m = tv[k].tm;
            press(1, 0, 6, 6);
            check($sformatf("cap_h[%0d]", k), {24'd0, set_h}, {24'd0, tv[k].th});
            check($sformatf("cap_m[%0d]", k), {24'd0, set_m}, {24'd0, tv[k].tm});
            check($sformatf("sel_h[%0d]", k), {29'd0, set_active, sel}, {29'd0, 1'b1, 2'b01});
            for (int n = 0; n < tv[k].nh; n++) press(0, 1, 6, 6);
            press(1, 0, 6, 6);
            check($sformatf("edit_h[%0d]", k), {24'd0, set_h}, {24'd0, tv[k].eh});
            check($sformatf("sel_m[%0d]", k), {30'd0, sel}, {30'd0, 2'b10});
            for (int n = 0; n < tv[k].nm; n++) press(0, 1, 6, 6);
            load_cnt = 0;
            press(1, 0, 6, 6);
            check($sformatf("load_once[%0d]", k), load_cnt, 32'd1);
            check($sformatf("final[%0d]", k), {13'd0, set_h, set_m, set_active, sel},
                  {13'd0, tv[k].eh, tv[k].em, 1'b0, 2'b00});
        end

        // Short press behaviour
        time_h = 8'h11; time_m = 8'h22;
`ifdef TIME_SET_DEBOUNCE_EN
        press(1, 0, 3, 10);
        check("glitch_no_event", {30'd0, sel}, 32'd0);
        press(1, 0, 20, 10);
        check("long_press_one_event", {30'd0, sel}, {30'd0, 2'b01});
`else
        @(negedge clk) btn_mode = 1'b0;
        @(posedge clk); #1;
        check("nodb_edge0", {30'd0, sel}, 32'd0);
        @(posedge clk); #1;
        check("nodb_edge1", {30'd0, sel}, 32'd0);
        @(posedge clk); #1;
        check("nodb_edge2", {30'd0, sel}, {30'd0, 2'b01});
        @(negedge clk) btn_mode = 1'b1;
        repeat (10) @(negedge clk);
        check("nodb_one_event", {30'd0, sel}, {30'd0, 2'b01});
`endif
        press(1, 0, 6, 6);
        press(1, 0, 6, 6);
        check("back_to_run", {30'd0, sel}, 32'd0);

        // Timeout abandons the edit without a load
        time_h = 8'h08; time_m = 8'h30;
        press(1, 0, 6, 6);
        press(0, 1, 6, 6);
        load_cnt = 0;
        repeat (80) @(negedge clk);
        check("tmo_not_yet", {30'd0, sel}, {30'd0, 2'b01});
        repeat (40) @(negedge clk);
        check("tmo_run", {29'd0, set_active, sel}, 32'd0);
        check("tmo_keep_h", {24'd0, set_h}, {24'd0, 8'h09});
        check("tmo_no_load", load_cnt, 32'd0);

        // Simultaneous mode+inc in SET_H, then reset mid-edit
        time_h = 8'h05; time_m = 8'h44;
        press(1, 0, 6, 6);
        press(1, 1, 6, 6);
        check("both_sel", {30'd0, sel}, {30'd0, 2'b10});
        check("both_h_kept", {24'd0, set_h}, {24'd0, 8'h05});
        load_cnt = 0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("reset_mid_edit", {11'd0, set_h, set_m, load_h, load_m, set_active, sel}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("after_reset_run", {30'd0, sel}, 32'd0);
        check("reset_no_load", load_cnt, 32'd0);

        // Random button traffic against the model
        for (int r = 0; r < 150; r++) begin
            int kind, hold, gap;
            if ($urandom_range(0, 9) == 0) begin
                time_h = 8'($urandom_range(0, 255));
                time_m = 8'($urandom_range(0, 255));
            end
            kind = $urandom_range(0, 9);
            hold = $urandom_range(1, 10);
            gap = ($urandom_range(0, 19) == 0) ? $urandom_range(80, 130) : $urandom_range(1, 15);
            press(kind < 4, kind >= 4 || kind == 0, hold, gap);
        end
        repeat (20) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
